// File: rtl/fwd_pkg.sv
// Shared forwarding definitions: operand-mux select codes and the shadow
// destination-register slot carried through EX, MEM and WB.
package fwd_pkg;

    localparam int FWD_REG_AW   = 5;
    localparam int FWD_NUM_REGS = 32;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_RSVD  = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } fwd_slot_t;

    // x0 is hardwired zero, so a slot targeting it never produces a value.
    function automatic logic slot_writes(input fwd_slot_t s,
                                         input logic [FWD_REG_AW-1:0] r);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-source select: the newest in-flight producer of rs wins (EX over MEM);
// rs == x0 always reads the register file.
module fwd_src_match
    import fwd_pkg::*;
(
    input  logic [FWD_REG_AW-1:0] rs_i,
    input  fwd_slot_t             ex_slot_i,
    input  fwd_slot_t             mem_slot_i,
    output logic [1:0]            sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (rs_i != '0) begin
            if (slot_writes(ex_slot_i, rs_i)) begin
                sel_o = FWD_EXMEM;
            end else if (slot_writes(mem_slot_i, rs_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

    logic unused_memread;
    assign unused_memread = ex_slot_i.memread ^ mem_slot_i.memread;

endmodule

// File: rtl/fwd_select_unit.sv
// EX-stage operand forwarding control: shadow rd pipeline, registered mux
// selects aligned with the ID/EX register, and combinational load-use stall.
module fwd_select_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = FWD_REG_AW,
    parameter int NUM_REGS = FWD_NUM_REGS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o
);

    if (REG_AW != FWD_REG_AW || NUM_REGS != (1 << REG_AW)) begin : g_param_check
        $error("fwd_select_unit: REG_AW/NUM_REGS disagree with fwd_pkg");
    end

    fwd_slot_t  ex_q, mem_q, wb_q;
    fwd_slot_t  ex_d;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic [1:0] fwd_a_d, fwd_b_d;
    logic [1:0] sel_a, sel_b;
    logic       load_use;
    logic       ex_load;

    // A load still in EX cannot feed the instruction in ID; hold ID for one cycle.
    always_comb begin
        load_use = id_valid_i && ex_q.valid && ex_q.memread &&
                   (slot_writes(ex_q, id_rs1_i) || slot_writes(ex_q, id_rs2_i));
    end

    assign ex_load = id_valid_i && !flush_i && !load_use;

    fwd_src_match u_match_a (
        .rs_i       (id_rs1_i),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .sel_o      (sel_a)
    );

    fwd_src_match u_match_b (
        .rs_i       (id_rs2_i),
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .sel_o      (sel_b)
    );

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (ex_load) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            fwd_a_d       = sel_a;
            fwd_b_d       = sel_b;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // WB distance is covered by the write-first register file; the slot is
    // tracked only to keep the shadow pipeline complete.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;
    assign stall_o = load_use;

endmodule

// File: tb/tb_fwd_select_unit.sv
// Bench for fwd_select_unit: directed pipeline scenarios then random traffic,
// checked against a queue model of the instructions that entered EX.
module tb_fwd_select_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       id_regwrite_i, id_memread_i, flush_i;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic       stall_o;

    int n_cmp = 0;
    int n_bad = 0;

    fwd_select_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o)
    );

    always #5 clk_i = ~clk_i;

    // pipe[0] = instruction now in EX, pipe[1] = MEM, pipe[2] = WB
    typedef struct {
        bit         valid;
        logic [4:0] rd;
        bit         rw;
        bit         mr;
    } ins_t;

    ins_t pipe[$];
    bit   last_stall;

    function automatic bit produces(ins_t s, logic [4:0] r);
        return s.valid && s.rw && s.rd != 0 && s.rd == r;
    endfunction

    function automatic logic [1:0] model_sel(logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (produces(pipe[0], rs)) return 2'b10;
        if (produces(pipe[1], rs)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        ins_t b;
        b = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(b);
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One ID-stage cycle: drive at negedge, check stall, clock, check selects.
    task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit rw, input bit mr, input bit fl);
        bit         exp_stall, enter;
        logic [1:0] ea, eb;
        ins_t       e;
        @(negedge clk_i);
        id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
        #1;
        exp_stall = v && pipe[0].valid && pipe[0].mr &&
                    (produces(pipe[0], rs1) || produces(pipe[0], rs2));
        check("stall", {1'b0, stall_o}, {1'b0, exp_stall});
        enter = v && !fl && !exp_stall;
        ea = enter ? model_sel(rs1) : 2'b00;
        eb = enter ? model_sel(rs2) : 2'b00;
        e = '{valid: enter, rd: rd, rw: rw, mr: mr};
        @(posedge clk_i);
        #1;
        pipe.push_front(e);
        void'(pipe.pop_back());
        check("fwd_a", fwd_a_o, ea);
        check("fwd_b", fwd_b_o, eb);
        last_stall = exp_stall;
    endtask

    initial begin
        rst_i = 1'b0;
        id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;
        model_reset();
        #3;
        check("rst_a", fwd_a_o, 2'b00);
        check("rst_b", fwd_b_o, 2'b00);
        check("rst_stall", {1'b0, stall_o}, 2'b00);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // back-to-back ALU forwarding
        step(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
        step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        check("b2b_a", fwd_a_o, 2'b10);
        check("b2b_b", fwd_b_o, 2'b10);
        step(1, 5'd0, 5'd5, 5'd8, 1, 0, 0);
        check("dist2_b", fwd_b_o, 2'b01);

        // EX producer beats MEM producer
        step(1, 5'd1, 5'd1, 5'd7, 1, 0, 0);
        step(1, 5'd2, 5'd2, 5'd7, 1, 0, 0);
        step(1, 5'd7, 5'd3, 5'd10, 1, 0, 0);
        check("prio_a", fwd_a_o, 2'b10);

        // load-use: one stall cycle, bubble, then MEM forwarding
        step(1, 5'd1, 5'd0, 5'd9, 1, 1, 0);
        step(1, 5'd3, 5'd9, 5'd11, 1, 0, 0);
        check("lu_stall", {1'b0, last_stall}, 2'b01);
        check("lu_bubble_b", fwd_b_o, 2'b00);
        step(1, 5'd3, 5'd9, 5'd11, 1, 0, 0);
        check("lu_nostall", {1'b0, last_stall}, 2'b00);
        check("lu_fwd_b", fwd_b_o, 2'b01);

        // load whose rd matches neither source
        step(1, 5'd1, 5'd0, 5'd12, 1, 1, 0);
        step(1, 5'd1, 5'd2, 5'd13, 1, 0, 0);
        check("ld_nomatch", {1'b0, last_stall}, 2'b00);

        // x0 producer is never forwarded
        step(1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
        step(1, 5'd0, 5'd0, 5'd14, 1, 0, 0);
        check("zero_a", fwd_a_o, 2'b00);

        // flushed producer never forwards
        step(1, 5'd1, 5'd1, 5'd13, 1, 0, 1);
        step(1, 5'd13, 5'd13, 5'd15, 0, 0, 0);
        check("flush_a", fwd_a_o, 2'b00);

        // flush coincident with load-use stall
        step(1, 5'd1, 5'd0, 5'd14, 1, 1, 0);
        step(1, 5'd14, 5'd2, 5'd15, 1, 0, 1);
        check("fl_stall", {1'b0, last_stall}, 2'b01);
        check("fl_bubble_a", fwd_a_o, 2'b00);
        step(1, 5'd14, 5'd2, 5'd15, 1, 0, 0);
        check("fl_after_a", fwd_a_o, 2'b01);

        // asynchronous reset with populated slots
        step(1, 5'd1, 5'd1, 5'd16, 1, 0, 0);
        step(1, 5'd16, 5'd0, 5'd17, 1, 1, 0);
        check("pre_rst_a", fwd_a_o, 2'b10);
        @(negedge clk_i);
        id_valid_i = 1'b1; id_rs1_i = 5'd17; id_rs2_i = 5'd0; flush_i = 1'b0;
        #1;
        check("pre_rst_stall", {1'b0, stall_o}, 2'b01);
        #1;
        rst_i = 1'b0;
        #1;
        check("arst_a", fwd_a_o, 2'b00);
        check("arst_b", fwd_b_o, 2'b00);
        check("arst_stall", {1'b0, stall_o}, 2'b00);
        model_reset();
        @(posedge clk_i);
        #1;
        check("arst_hold_a", fwd_a_o, 2'b00);
        @(negedge clk_i);
        rst_i = 1'b1;

        // random traffic over a small register window to force hits
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
